prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream boot loader upstream of the single-cycle datapath. Receives a framed image on a
//  valid/ready byte port, assembles 32-bit words, and drives the datapath programming inputs
//  (prog, blockAddr, Iword). It then pulses loadPC with the image start PC to hand off into run mode.
//  It owns the datapath's prog/loadPC/initPC/blockAddr/Iword inputs outright.
// PARAMETERS
//  N      32   instruction word width; must be a multiple of 8
//  ADDR_W 7    instruction-cache word address width (depth 2**ADDR_W = 128)
//  PC_W   30   word-address PC width
// PORTS
//  clk        in   1       single clock; all state on posedge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: abort any activity, restart at HDR
//  in_valid   in   1       byte available
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts byte this cycle (transfer = in_valid & in_ready)
//  prog       out  1       1 = cache programming mode (datapath halted), 0 = run
//  loadPC     out  1       1 = datapath PC forced to initPC on next edge
//  initPC     out  PC_W    start word address from header
//  blockAddr  out  ADDR_W  cache write address
//  Iword      out  N       cache write data
//  iwr        out  1       1-cycle strobe: blockAddr/Iword carry a newly completed word
//  done       out  1       image loaded and running (level)
//  err        out  1       bad header (level, cleared by start or reset)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=HDR, prog=1, loadPC=1, initPC=0, blockAddr=0, Iword=0, iwr=0,
//   done=0, err=0, in_ready=0 while rst_n low; in_ready=1 from first edge after release.
//  Frame (little-endian): 4 bytes PC (bits[PC_W-1:0] kept, upper discarded), 1 byte count C,
//   then C*(N/8) word bytes. C=0 or C>2**ADDR_W -> ERR.
//  States: HDR(PC bytes 0..3) -> CNT -> DATA -> LAUNCH -> RUN; ERR.
//   HDR/CNT/DATA: in_ready=1, prog=1, loadPC=1 (PC pinned to initPC while loading).
//   initPC updates when the 4th PC byte is accepted.
//   DATA: word index w from 0; byte k of word lands in Iword bits [8k+7:8k] via assembler.
//   On the (N/8)th byte: Iword/blockAddr update on that edge, iwr=1 for exactly that cycle.
//   blockAddr = (initPC[ADDR_W-1:0] + w) mod 2**ADDR_W; wraps 127->0 silently.
//   Between words Iword/blockAddr hold the last written value (cache is clocked every cycle
//   while prog=1; rewriting the same word is harmless). In HDR/CNT they hold the prior value.
//   Last byte of word C-1 accepted -> LAUNCH (in_ready=0 from that edge on).
//   LAUNCH: exactly 1 cycle, prog=0, loadPC=1 -> datapath PC := initPC, cache in read mode.
//   RUN: prog=0, loadPC=0, done=1, in_ready=0; stays until start or reset.
//   ERR: entered on the edge accepting bad C; err=1, prog=1, loadPC=1, in_ready=1,
//    bytes drained and discarded; exits only on start.
//  start (any state, priority over byte transfer): in_ready=0 in the start cycle; byte
//   offered that cycle is NOT consumed. Next state HDR, byte counters cleared, done=0, err=0,
//   prog=1, loadPC=1. Partial word discarded; already-written cache words remain.
//  in_valid=0 mid-word: assembler holds partial bytes indefinitely, no timeout.
//  Latency: word written on the edge accepting its last byte; LAUNCH follows the last word's
//   edge; done rises 2 edges after the final byte.
//  Counters: byte-in-field 0..3 (2b), word count 0..2**ADDR_W (ADDR_W+1 bits; no overflow).
// STRUCTURE
//  loader_pkg: state encoding (HDR, CNT, DATA, LAUNCH, RUN, ERR), HDR_BYTES=4,
//   BYTES_PER_WORD=N/8, max-count constant.
//  Sub-module byte_assembler: shift/insert register + byte index; outputs word + word_done;
//   has a synchronous clear driven by start. FSM, address, and flag logic stay in prog_loader.
// TESTING
//  1) PC=0x00000010, C=2, words 0x20080005,0x01094020 -> iwr at blockAddr 0x10,0x11
//     with those Iwords; LAUNCH initPC=0x10; done=1.
//  2) PC=0x7E, C=3 -> blockAddr 0x7E,0x7F,0x00 (wrap); done=1.
//  3) C=0 and (separately) C=129 -> err=1, prog=1, bytes still accepted.
//     start then a good frame -> err=0, done=1.
//  4) Random in_valid gaps (30% idle) on test 1 -> identical iwr sequence and contents.
//  5) start asserted on the 3rd byte of word 1 with in_valid=1 -> byte not consumed, HDR,
//     done=0, no iwr. New frame loads correctly.
//  6) rst_n low mid-DATA (between edges) -> outputs take reset values immediately, no iwr;
//     after release a full frame completes; prog is 0 only in LAUNCH/RUN.

Source files
------------

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : loader_pkg
// Description : State encoding and framing constants for the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int DEF_N          = 32;
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_PC_W       = 30;
    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = DEF_N / 8;
    localparam int MAX_COUNT      = 2 ** DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_HDR    = 3'd0,
        ST_CNT    = 3'd1,
        ST_DATA   = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : byte_assembler
// Description : Collects little-endian bytes into an N-bit word; word_done
//               flags the byte that completes it (word is valid that cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module byte_assembler
    import loader_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         byte_valid,
    input  logic [7:0]   byte_data,
    output logic [N-1:0] word,
    output logic         word_done
);

    localparam int BPW   = N / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(BPW - 1);

    logic [N-1:0]     r_word;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (clr) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (byte_valid) begin
            r_word[8*r_idx +: 8] <= byte_data;
            r_idx                <= (r_idx == C_LAST) ? '0 : r_idx + IDX_W'(1);
        end
    end

    // Current byte merged in combinationally so the full word is ready on its last byte
    always_comb begin
        word                 = r_word;
        word[8*r_idx +: 8]   = byte_data;
    end

    assign word_done = byte_valid & (r_idx == C_LAST);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Framed byte-stream boot loader that programs the instruction
//               cache and hands the datapath off to run mode at the image PC.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              prog,
    output logic              loadPC,
    output logic [PC_W-1:0]   initPC,
    output logic [ADDR_W-1:0] blockAddr,
    output logic [N-1:0]      Iword,
    output logic              iwr,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [7:0] C_MAX_CNT = 8'(MAX_COUNT);

    state_t           r_state, w_state_next;
    logic             r_rdy;
    logic [1:0]       r_hdr_idx;
    logic [23:0]      r_pc_lo;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_w;
    logic             w_xfer;
    logic             w_bad_cnt;
    logic             w_word_done;
    logic [N-1:0]     w_word;
    logic             w_last_word;

    assign w_xfer      = in_valid & in_ready;
    assign w_bad_cnt   = (in_data == 8'd0) || (in_data > C_MAX_CNT);
    assign w_last_word = (r_w + CNT_W'(1)) == r_count;

    assign in_ready = r_rdy & ~start &
                      ((r_state == ST_HDR) || (r_state == ST_CNT) ||
                       (r_state == ST_DATA) || (r_state == ST_ERR));
    assign prog     = (r_state != ST_LAUNCH) && (r_state != ST_RUN);
    assign loadPC   = (r_state != ST_RUN);
    assign done     = (r_state == ST_RUN);
    assign err      = (r_state == ST_ERR);

    byte_assembler #(.N(N)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start),
        .byte_valid (w_xfer && (r_state == ST_DATA)),
        .byte_data  (in_data),
        .word       (w_word),
        .word_done  (w_word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HDR;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = ST_HDR;
        end else begin
            case (r_state)
                ST_HDR:    if (w_xfer && (r_hdr_idx == 2'(HDR_BYTES - 1))) w_state_next = ST_CNT;
                ST_CNT:    if (w_xfer) w_state_next = w_bad_cnt ? ST_ERR : ST_DATA;
                ST_DATA:   if (w_word_done && w_last_word) w_state_next = ST_LAUNCH;
                ST_LAUNCH: w_state_next = ST_RUN;
                ST_RUN:    w_state_next = ST_RUN;
                ST_ERR:    w_state_next = ST_ERR;
                default:   w_state_next = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy     <= 1'b0;
            r_hdr_idx <= '0;
            r_pc_lo   <= '0;
            r_count   <= '0;
            r_w       <= '0;
            initPC    <= '0;
            blockAddr <= '0;
            Iword     <= '0;
            iwr       <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            iwr   <= 1'b0;
            if (start) begin
                r_hdr_idx <= '0;
                r_w       <= '0;
            end else if (w_xfer) begin
                case (r_state)
                    ST_HDR: begin
                        r_hdr_idx <= r_hdr_idx + 2'd1;
                        if (r_hdr_idx == 2'(HDR_BYTES - 1))
                            // Upper header bits beyond PC_W are discarded
                            initPC <= {in_data[PC_W-25:0], r_pc_lo};
                        else
                            r_pc_lo[8*r_hdr_idx +: 8] <= in_data;
                    end
                    ST_CNT: begin
                        r_count <= in_data[CNT_W-1:0];
                        r_w     <= '0;
                    end
                    ST_DATA: begin
                        if (w_word_done) begin
                            Iword     <= w_word;
                            blockAddr <= initPC[ADDR_W-1:0] + r_w[ADDR_W-1:0];
                            iwr       <= 1'b1;
                            r_w       <= r_w + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Scoreboard bench for prog_loader: cache writes are queued at
//               issue time and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, prog, loadPC, iwr, done, err;
    logic [29:0] initPC;
    logic [6:0]  blockAddr;
    logic [31:0] Iword;

    int n_checks = 0;
    int n_fail   = 0;
    bit gap_en   = 1'b0;
    logic [6:0]  cur_base;
    logic [6:0]  cur_idx;
    logic [38:0] exp_q[$];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prog(prog), .loadPC(loadPC), .initPC(initPC),
        .blockAddr(blockAddr), .Iword(Iword), .iwr(iwr), .done(done), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cache write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && iwr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_iwr", {25'd0, blockAddr}, 32'hFFFF_FFFF);
            end else begin
                logic [38:0] e;
                e = exp_q.pop_front();
                check("iwr_addr", {25'd0, blockAddr}, {25'd0, e[38:32]});
                check("iwr_word", Iword, e[31:0]);
            end
        end
    end

    // Returns at posedge+1 with in_valid dropped
    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gap_en) while ($urandom_range(0, 99) < 30) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        n = 0;
        while (in_ready !== 1'b1) begin
            if (n == 20) begin
                check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
                break;
            end
            @(negedge clk); #1;
            n++;
        end
        check("prog_while_loading", {31'd0, prog}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] pc, input logic [7:0] cnt);
        for (int i = 0; i < 4; i++) send_byte(pc[8*i +: 8]);
        send_byte(cnt);
        cur_base = pc[6:0];
        cur_idx  = 7'd0;
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes);
        if (nbytes == 4) begin
            exp_q.push_back({cur_base + cur_idx, w});
            cur_idx = cur_idx + 7'd1;
        end
        for (int i = 0; i < nbytes; i++) send_byte(w[8*i +: 8]);
    endtask

    // Called right after the final byte: LAUNCH now, RUN one edge later
    task automatic finish_check(input logic [29:0] exp_pc);
        check("launch_prog", {31'd0, prog}, 32'd0);
        check("launch_loadPC", {31'd0, loadPC}, 32'd1);
        check("launch_done", {31'd0, done}, 32'd0);
        check("launch_in_ready", {31'd0, in_ready}, 32'd0);
        check("launch_initPC", {2'd0, initPC}, {2'd0, exp_pc});
        @(posedge clk); #1;
        check("run_done", {31'd0, done}, 32'd1);
        check("run_loadPC", {31'd0, loadPC}, 32'd0);
        check("run_prog", {31'd0, prog}, 32'd0);
        check("run_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        check("start_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_done", {31'd0, done}, 32'd0);
        check("start_err", {31'd0, err}, 32'd0);
        check("start_prog", {31'd0, prog}, 32'd1);
        check("start_loadPC", {31'd0, loadPC}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prog"}, {31'd0, prog}, 32'd1);
        check({tag, "_loadPC"}, {31'd0, loadPC}, 32'd1);
        check({tag, "_initPC"}, {2'd0, initPC}, 32'd0);
        check({tag, "_blockAddr"}, {25'd0, blockAddr}, 32'd0);
        check({tag, "_Iword"}, Iword, 32'd0);
        check({tag, "_iwr"}, {31'd0, iwr}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", {31'd0, in_ready}, 32'd1);

        // 1) basic two-word image
        send_hdr(32'h0000_0010, 8'd2);
        send_word(32'h2008_0005, 4);
        send_word(32'h0109_4020, 4);
        finish_check(30'h10);

        // 2) address wrap
        do_start();
        send_hdr(32'h0000_007E, 8'd3);
        send_word(32'h1111_1111, 4);
        send_word(32'h2222_2222, 4);
        send_word(32'h3333_3333, 4);
        finish_check(30'h7E);

        // 3) bad counts
        do_start();
        send_hdr(32'h0000_0001, 8'd0);
        check("c0_err", {31'd0, err}, 32'd1);
        check("c0_prog", {31'd0, prog}, 32'd1);
        check("c0_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) send_byte(8'h55);
        check("c0_err_hold", {31'd0, err}, 32'd1);
        do_start();
        send_hdr(32'h0000_0002, 8'd129);
        check("c129_err", {31'd0, err}, 32'd1);
        check("c129_in_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h66);
        do_start();
        send_hdr(32'hFFFF_FF20, 8'd1);
        check("good_err_clear", {31'd0, err}, 32'd0);
        send_word(32'hCAFE_BABE, 4);
        finish_check(30'h3FFF_FF20);

        // 4) test 1 again with random idle gaps
        do_start();
        gap_en = 1'b1;
        send_hdr(32'h0000_0010, 8'd2);
        send_word(32'h2008_0005, 4);
        send_word(32'h0109_4020, 4);
        gap_en = 1'b0;
        finish_check(30'h10);

        // 5) start lands on third byte of word 1
        do_start();
        send_hdr(32'h0000_0020, 8'd3);
        send_word(32'hA1A2_A3A4, 4);
        send_word(32'hB1B2_B3B4, 2);
        do_start();
        send_hdr(32'h0000_0030, 8'd1);
        send_word(32'h1234_5678, 4);
        finish_check(30'h30);

        // 6) async reset mid-DATA
        do_start();
        send_hdr(32'h0000_0040, 8'd2);
        send_word(32'hDEAD_BEEF, 4);
        send_word(32'h0BAD_F00D, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("rel_in_ready_high", {31'd0, in_ready}, 32'd1);
        send_hdr(32'h0000_0005, 8'd2);
        send_word(32'h0F0E_0D0C, 4);
        send_word(32'h7060_5040, 4);
        finish_check(30'h05);

        repeat (3) @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
